// File: rtl/tour_cmd_responder.sv
// Responder end of the tour command handshake. It captures a 16-bit command,
// acknowledges it, and then emulates the knight's travel one square at a time.
// It also calibrates, sets the position directly, or rejects bad commands.
// When the command is done it pulses send_resp.
//
// Ports:
//   clk          system clock
//   rst          asynchronous reset, active high
//   cmd          [15:12] opcode, [11:4] heading, [3:0] squares
//   cmd_rdy      command valid, held by the initiator until acknowledged
//   clr_cmd_rdy  one-cycle acknowledge (state ACK)
//   send_resp    one-cycle completion pulse (state RESP)
//   busy         high from ACK through RESP
//   x_pos/y_pos  current board position (0..4)
//   fanfare      with send_resp on a successful opcode 0x3
//   err          command rejected; valid with send_resp, held until next capture
//
// state | meaning
// IDLE  | waiting for cmd_rdy; a sampled cmd_rdy captures cmd
// ACK   | acknowledge, decode, bounds check, set-position update
// EXEC  | travelling; one square per SQ_CYC cycles
// CAL   | calibrate wait of CAL_CYC cycles
// RESP  | completion pulse, fanfare if applicable
module tour_cmd_responder #(
    parameter int SQ_CYC  = 16,
    parameter int CAL_CYC = 8,
    parameter int INIT_X  = 2,
    parameter int INIT_Y  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cmd,
    input  logic        cmd_rdy,
    output logic        clr_cmd_rdy,
    output logic        send_resp,
    output logic        busy,
    output logic [2:0]  x_pos,
    output logic [2:0]  y_pos,
    output logic        fanfare,
    output logic        err
);

    localparam int CNT_MAX = (SQ_CYC > CAL_CYC) ? SQ_CYC : CAL_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {IDLE, ACK, EXEC, CAL, RESP} state_t;

    state_t         state, state_nxt;
    logic [15:0]    cmd_reg;
    logic [CW-1:0]  cnt;
    logic [3:0]     remaining;
    logic           ack_err;

    logic [3:0] opcode;
    logic [7:0] heading;
    logic [3:0] squares;
    logic [4:0] sq5, x5, y5;
    logic       sq_tc, cal_tc;

    assign opcode  = cmd_reg[15:12];
    assign heading = cmd_reg[11:4];
    assign squares = cmd_reg[3:0];
    // The sums below can reach 4 + 15, so 5 bits are enough and nothing wraps.
    assign sq5     = {1'b0, squares};
    assign x5      = {2'b0, x_pos};
    assign y5      = {2'b0, y_pos};
    assign sq_tc   = (cnt == CW'(SQ_CYC - 1));
    assign cal_tc  = (cnt == CW'(CAL_CYC - 1));

    // Decode and bounds check of the captured command against the current position.
    always_comb begin
        ack_err = 1'b0;
        case (opcode)
            4'h0: ack_err = 1'b0;
            4'h2, 4'h3: begin
                case (heading)
                    8'h00:   ack_err = (y5 + sq5) > 5'd4;
                    8'h7F:   ack_err = sq5 > y5;
                    8'hBF:   ack_err = (x5 + sq5) > 5'd4;
                    8'h3F:   ack_err = sq5 > x5;
                    default: ack_err = 1'b1;
                endcase
            end
            4'h4:    ack_err = (cmd_reg[6:4] > 3'd4) || (cmd_reg[2:0] > 3'd4);
            default: ack_err = 1'b1;
        endcase
    end

    always_comb begin
        state_nxt   = state;
        clr_cmd_rdy = 1'b0;
        send_resp   = 1'b0;
        busy        = 1'b1;
        fanfare     = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (cmd_rdy) state_nxt = ACK;
            end
            ACK: begin
                clr_cmd_rdy = 1'b1;
                if (ack_err || opcode == 4'h4 || (opcode != 4'h0 && squares == 4'd0))
                    state_nxt = RESP;
                else if (opcode == 4'h0)
                    state_nxt = CAL;
                else
                    state_nxt = EXEC;
            end
            EXEC: if (sq_tc && remaining == 4'd1) state_nxt = RESP;
            CAL:  if (cal_tc) state_nxt = RESP;
            RESP: begin
                send_resp = 1'b1;
                fanfare   = (opcode == 4'h3) && !err;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cmd_reg   <= '0;
            cnt       <= '0;
            remaining <= '0;
            err       <= 1'b0;
            x_pos     <= 3'(INIT_X);
            y_pos     <= 3'(INIT_Y);
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (cmd_rdy) begin
                        cmd_reg <= cmd;
                        err     <= 1'b0;
                    end
                end
                ACK: begin
                    err       <= ack_err;
                    cnt       <= '0;
                    remaining <= squares;
                    if (opcode == 4'h4 && !ack_err) begin
                        x_pos <= cmd_reg[6:4];
                        y_pos <= cmd_reg[2:0];
                    end
                end
                EXEC: begin
                    if (sq_tc) begin
                        cnt       <= '0;
                        remaining <= remaining - 4'd1;
                        case (heading)
                            8'h00:   y_pos <= y_pos + 3'd1;
                            8'h7F:   y_pos <= y_pos - 3'd1;
                            8'hBF:   x_pos <= x_pos + 3'd1;
                            default: x_pos <= x_pos - 3'd1;
                        endcase
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CAL: cnt <= cnt + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tour_cmd_responder.sv
module tb_tour_cmd_responder;

    localparam int SQ  = 4;
    localparam int CAL = 3;
    localparam int IX  = 2;
    localparam int IY  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cmd = '0;
    logic        cmd_rdy = 1'b0;
    logic        clr_cmd_rdy, send_resp, busy, fanfare, err;
    logic [2:0]  x_pos, y_pos;

    int n_chk  = 0;
    int n_fail = 0;
    int mx = IX;
    int my = IY;

    tour_cmd_responder #(.SQ_CYC(SQ), .CAL_CYC(CAL), .INIT_X(IX), .INIT_Y(IY)) dut (
        .clk(clk), .rst(rst), .cmd(cmd), .cmd_rdy(cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .busy(busy),
        .x_pos(x_pos), .y_pos(y_pos), .fanfare(fanfare), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model. It gives the outcome of a command from position (mx,my).
    task automatic model(input logic [15:0] c, output int e, output int fan, output int lat,
                         output int steps, output int dx, output int dy,
                         output int fx, output int fy, output int setpos);
        int op, hd, sq, tx, ty;
        op = int'(c[15:12]); hd = int'(c[11:4]); sq = int'(c[3:0]);
        e = 0; lat = 2; steps = 0; dx = 0; dy = 0; fx = mx; fy = my; setpos = 0;
        case (op)
            0: lat = 2 + CAL;
            2, 3: begin
                if      (hd == 8'h00) dy = 1;
                else if (hd == 8'h7F) dy = -1;
                else if (hd == 8'hBF) dx = 1;
                else if (hd == 8'h3F) dx = -1;
                else e = 1;
                if (e == 0) begin
                    tx = mx + dx * sq;
                    ty = my + dy * sq;
                    if (tx < 0 || tx > 4 || ty < 0 || ty > 4) e = 1;
                    else begin
                        fx = tx; fy = ty; steps = sq; lat = 2 + sq * SQ;
                    end
                end
            end
            4: begin
                tx = int'(c[6:4]); ty = int'(c[2:0]);
                if (tx > 4 || ty > 4) e = 1;
                else begin fx = tx; fy = ty; setpos = 1; end
            end
            default: e = 1;
        endcase
        fan = (op == 3 && e == 0) ? 1 : 0;
        if (e == 1) begin dx = 0; dy = 0; end
    endtask

    // Issue one command (call at a negedge) and check every cycle through the first IDLE cycle.
    task automatic run_cmd(input logic [15:0] c);
        int e, fan, lat, steps, dx, dy, fx, fy, setpos, done, ex, ey;
        model(c, e, fan, lat, steps, dx, dy, fx, fy, setpos);
        cmd = c;
        cmd_rdy = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= lat + 1; n++) begin
            @(negedge clk);
            if (setpos == 1) begin
                ex = (n >= 2) ? fx : mx;
                ey = (n >= 2) ? fy : my;
            end else begin
                done = (n < 2) ? 0 : (n - 2) / SQ;
                if (done > steps) done = steps;
                ex = mx + dx * done;
                ey = my + dy * done;
            end
            chk("clr_cmd_rdy", int'(clr_cmd_rdy), (n == 1) ? 1 : 0);
            chk("send_resp", int'(send_resp), (n == lat) ? 1 : 0);
            chk("busy", int'(busy), (n <= lat) ? 1 : 0);
            chk("fanfare", int'(fanfare), (n == lat) ? fan : 0);
            chk("err", int'(err), (n == 1) ? 0 : e);
            chk("x_pos", int'(x_pos), ex);
            chk("y_pos", int'(y_pos), ey);
            if (n == 1) cmd_rdy = 1'b0;
        end
        mx = fx;
        my = fy;
    endtask

    initial begin
        logic [15:0] c;
        int pick;

        repeat (3) @(negedge clk);
        chk("rst_clr", int'(clr_cmd_rdy), 0);
        chk("rst_resp", int'(send_resp), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_fan", int'(fanfare), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_x", int'(x_pos), IX);
        chk("rst_y", int'(y_pos), IY);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        run_cmd(16'h2002);          // north 2 from (2,2)
        run_cmd(16'h4022);          // back to (2,2)
        run_cmd(16'h33F1);          // west 1 with fanfare
        run_cmd(16'h4024);          // (2,4)
        run_cmd(16'h2001);          // off board north -> err
        repeat (3) begin
            @(negedge clk);
            chk("err_hold", int'(err), 1);
        end
        run_cmd(16'h4043);
        run_cmd(16'h5000);
        run_cmd(16'h2121);
        run_cmd(16'h4077);          // set-position out of range
        run_cmd(16'h0000);          // calibrate
        run_cmd(16'h2000);          // zero squares
        run_cmd(16'h4022);
        run_cmd(16'h2002);          // knight L: north 2 ...
        run_cmd(16'h3BF1);          // ... then east 1 with fanfare
        chk("l_final_x", int'(x_pos), 3);
        chk("l_final_y", int'(y_pos), 4);

        // Reset during EXEC after one square
        run_cmd(16'h4000);
        cmd = 16'h2003;
        cmd_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_rdy = 1'b0;
        repeat (SQ + 1) @(negedge clk);
        chk("mid_y_one_sq", int'(y_pos), 1);
        rst = 1'b1;
        #1;
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_resp", int'(send_resp), 0);
        chk("mrst_err", int'(err), 0);
        chk("mrst_x", int'(x_pos), IX);
        chk("mrst_y", int'(y_pos), IY);
        @(negedge clk);
        rst = 1'b0;
        mx = IX;
        my = IY;
        repeat (4 * SQ) begin
            @(negedge clk);
            chk("mrst_no_resp", int'(send_resp), 0);
        end
        run_cmd(16'h2BF2);

        // Randomized commands
        for (int i = 0; i < 60; i++) begin
            pick = int'($urandom_range(0, 9));
            c = 16'($urandom);
            case (pick)
                0, 1, 2, 3, 4: begin
                    c[15:12] = ($urandom_range(0, 1) == 0) ? 4'h2 : 4'h3;
                    case ($urandom_range(0, 4))
                        0: c[11:4] = 8'h00;
                        1: c[11:4] = 8'h7F;
                        2: c[11:4] = 8'hBF;
                        3: c[11:4] = 8'h3F;
                        default: ;
                    endcase
                    if ($urandom_range(0, 3) != 0) c[3:0] = 4'($urandom_range(0, 4));
                end
                5, 6: c[15:12] = 4'h4;
                7:    c[15:12] = 4'h0;
                default: ;
            endcase
            run_cmd(c);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
